seg_display_ctrl: RTL and testbench

Arbiter and frame-commit controller that shares the 4-digit 7-segment display between two requesters (A and B). Each requester writes digits into a private shadow frame over a valid/ready handshake, and ends the frame with a "last" beat. On that beat the shadow frame is committed atomically to the registered val/dot outputs. Those outputs feed the display scan-multiplexer directly, so the display never shows a half-written frame.

---
 rtl/seg_display_ctrl.sv | 173 +++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
// Shares the 4-digit 7-segment display between two requesters (A and B).
// Each requester writes {val,dot} beats into a private shadow frame over a
// valid/ready handshake. A beat with last=1 ends the frame, and the whole
// shadow frame is then committed atomically to the registered display outputs.
// Because of this the scan multiplexer never shows a half-written frame.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid/a_ready/a_digit/   requester A beat handshake and payload
//   a_val/a_dot/a_last
//   b_*                        same for requester B
//   val0..val3, dot0..dot3     committed display digits and decimal points
//   busy, owner                grant held, and by whom (0=A, 1=B)
//   commit                     one-cycle pulse after a frame is committed
//   abort                      one-cycle pulse when the owner's frame times out
module seg_display_ctrl #(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned TW      = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [1:0] a_digit,
    input  logic [3:0] a_val,
    input  logic       a_dot,
    input  logic       a_last,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [1:0] b_digit,
    input  logic [3:0] b_val,
    input  logic       b_dot,
    input  logic       b_last,
    output logic [3:0] val0,
    output logic [3:0] val1,
    output logic [3:0] val2,
    output logic [3:0] val3,
    output logic       dot0,
    output logic       dot1,
    output logic       dot2,
    output logic       dot3,
    output logic       busy,
    output logic       owner,
    output logic       commit,
    output logic       abort
);

    typedef enum logic [1:0] {StIdle, StOwn, StCommit} state_e;

    // The abort fires on the TIMEOUT-th consecutive idle cycle. At that point the counter holds
    // TIMEOUT-1.
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);

    state_e        state_q;
    logic [15:0]   shadow_val_q;
    logic [3:0]    shadow_dot_q;
    logic [15:0]   disp_val_q;
    logic [3:0]    disp_dot_q;
    logic          busy_q;
    logic          owner_q;
    logic          commit_q;
    logic          abort_q;
    logic          a_ready_q;
    logic          b_ready_q;
    logic          rr_q;       // 0: A wins a tie, 1: B wins a tie
    logic [TW-1:0] cnt_q;

    logic       grant_b;
    logic       beat_fire;
    logic [1:0] beat_digit;
    logic [3:0] beat_val;
    logic       beat_dot;
    logic       beat_last;

    always_comb begin
        grant_b    = b_valid & (~a_valid | rr_q);
        // Only the owner's lane is looked at; the other side's valid is ignored.
        beat_fire  = (state_q == StOwn) &
                     (owner_q ? (b_valid & b_ready_q) : (a_valid & a_ready_q));
        beat_digit = owner_q ? b_digit : a_digit;
        beat_val   = owner_q ? b_val   : a_val;
        beat_dot   = owner_q ? b_dot   : a_dot;
        beat_last  = owner_q ? b_last  : a_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            shadow_val_q <= '0;
            shadow_dot_q <= '0;
            disp_val_q   <= '0;
            disp_dot_q   <= '0;
            busy_q       <= 1'b0;
            owner_q      <= 1'b0;
            commit_q     <= 1'b0;
            abort_q      <= 1'b0;
            a_ready_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            rr_q         <= 1'b0;
            cnt_q        <= '0;
        end else begin
            commit_q <= 1'b0;
            abort_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    a_ready_q <= 1'b0;
                    b_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (a_valid | b_valid) begin
                        state_q      <= StOwn;
                        busy_q       <= 1'b1;
                        owner_q      <= grant_b;
                        a_ready_q    <= ~grant_b;
                        b_ready_q    <= grant_b;
                        // Seed from what is on display so unwritten digits keep their value.
                        shadow_val_q <= disp_val_q;
                        shadow_dot_q <= disp_dot_q;
                        cnt_q        <= '0;
                    end
                end
                StOwn: begin
                    if (beat_fire) begin
                        shadow_val_q[{beat_digit, 2'b00} +: 4] <= beat_val;
                        shadow_dot_q[beat_digit]               <= beat_dot;
                        cnt_q                                  <= '0;
                        if (beat_last) begin
                            state_q   <= StCommit;
                            a_ready_q <= 1'b0;
                            b_ready_q <= 1'b0;
                        end
                    end else if (cnt_q == TimeoutLast) begin
                        // Drop the frame; display outputs are left untouched.
                        state_q   <= StIdle;
                        abort_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        a_ready_q <= 1'b0;
                        b_ready_q <= 1'b0;
                        cnt_q     <= '0;
                        rr_q      <= ~owner_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StCommit: begin
                    disp_val_q <= shadow_val_q;
                    disp_dot_q <= shadow_dot_q;
                    commit_q   <= 1'b1;
                    rr_q       <= ~owner_q;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign a_ready = a_ready_q;
    assign b_ready = b_ready_q;
    assign val0    = disp_val_q[3:0];
    assign val1    = disp_val_q[7:4];
    assign val2    = disp_val_q[11:8];
    assign val3    = disp_val_q[15:12];
    assign dot0    = disp_dot_q[0];
    assign dot1    = disp_dot_q[1];
    assign dot2    = disp_dot_q[2];
    assign dot3    = disp_dot_q[3];
    assign busy    = busy_q;
    assign owner   = owner_q;
    assign commit  = commit_q;
    assign abort   = abort_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl. Inputs change and outputs are sampled 1ns after the
// rising edge.
module tb_seg_display_ctrl;

    localparam int unsigned TIMEOUT = 10;
    localparam int unsigned TW      = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, a_ready, a_dot, a_last;
    logic [1:0] a_digit;
    logic [3:0] a_val;
    logic       b_valid, b_ready, b_dot, b_last;
    logic [1:0] b_digit;
    logic [3:0] b_val;
    logic [3:0] val0, val1, val2, val3;
    logic       dot0, dot1, dot2, dot3;
    logic       busy, owner, commit, abort;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] vals;
    logic [3:0]  dots;
    assign vals = {val3, val2, val1, val0};
    assign dots = {dot3, dot2, dot1, dot0};

    seg_display_ctrl #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_digit(a_digit), .a_val(a_val),
        .a_dot(a_dot), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_digit(b_digit), .b_val(b_val),
        .b_dot(b_dot), .b_last(b_last),
        .val0(val0), .val1(val1), .val2(val2), .val3(val3),
        .dot0(dot0), .dot1(dot1), .dot2(dot2), .dot3(dot3),
        .busy(busy), .owner(owner), .commit(commit), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [1:0] d, input logic [3:0] x,
                         input logic dp, input logic l);
        a_valid = v; a_digit = d; a_val = x; a_dot = dp; a_last = l;
    endtask

    task automatic set_b(input logic v, input logic [1:0] d, input logic [3:0] x,
                         input logic dp, input logic l);
        b_valid = v; b_digit = d; b_val = x; b_dot = dp; b_last = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_a(1'b1, 2'd0, 4'h1, 1'b0, 1'b0);
        set_b(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        repeat (2) tick();
        n_checks++;
        if ({vals, dots} !== 20'h0) begin
            n_fail++; $display("FAIL reset_display: got %h want 00000", {vals, dots});
        end
        n_checks++;
        if ({busy, owner, commit, abort, a_ready, b_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {busy, owner, commit, abort, a_ready, b_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (a_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_first_cycle_ready: got %b want 0", a_ready);
        end
        tick();
        n_checks++;
        if ({busy, owner, a_ready, b_ready} !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_grant_a: busy/owner/a_ready/b_ready got %b want 1010",
                     {busy, owner, a_ready, b_ready});
        end
    endtask

    // A owns the grant on entry.
    task automatic test_frame_a();
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 2'(i), 4'(i + 1), (i == 2), (i == 3));
            tick();
            n_checks++;
            if (vals !== 16'h0) begin
                n_fail++; $display("FAIL frame_a_hold_%0d: got %h want 0000", i, vals);
            end
        end
        n_checks++;
        if ({a_ready, commit, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL frame_a_commit_state: a_ready/commit/busy got %b want 001",
                     {a_ready, commit, busy});
        end
        a_valid = 1'b0;
        tick();
        n_checks++;
        if (vals !== 16'h4321 || dots !== 4'b0100) begin
            n_fail++; $display("FAIL frame_a_values: got %h/%b want 4321/0100", vals, dots);
        end
        n_checks++;
        if ({commit, busy} !== 2'b10) begin
            n_fail++; $display("FAIL frame_a_pulse: commit/busy got %b want 10", {commit, busy});
        end
        tick();
        n_checks++;
        if (commit !== 1'b0) begin
            n_fail++; $display("FAIL frame_a_pulse_once: got %b want 0", commit);
        end
    endtask

    task automatic test_arbitration();
        rst_n = 1'b0;
        set_a(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        set_b(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        set_a(1'b1, 2'd0, 4'h5, 1'b0, 1'b0);
        set_b(1'b1, 2'd1, 4'hF, 1'b0, 1'b1);
        tick();
        n_checks++;
        if ({busy, owner, a_ready, b_ready} !== 4'b1010) begin
            n_fail++;
            $display("FAIL arb_tie_to_a: busy/owner/a_ready/b_ready got %b want 1010",
                     {busy, owner, a_ready, b_ready});
        end
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 2'(i), 4'(i + 5), 1'b0, (i == 3));
            tick();
        end
        n_checks++;
        if (b_ready !== 1'b0) begin
            n_fail++; $display("FAIL arb_b_blocked: got %b want 0", b_ready);
        end
        // A keeps requesting; B must still win the next grant.
        set_a(1'b1, 2'd2, 4'h0, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (vals !== 16'h8765 || commit !== 1'b1) begin
            n_fail++; $display("FAIL arb_a_commit: got %h/%b want 8765/1", vals, commit);
        end
        tick();
        n_checks++;
        if ({busy, owner, a_ready, b_ready} !== 4'b1101) begin
            n_fail++;
            $display("FAIL arb_grant_b: busy/owner/a_ready/b_ready got %b want 1101",
                     {busy, owner, a_ready, b_ready});
        end
        tick();
        b_valid = 1'b0;
        a_valid = 1'b0;
        tick();
        n_checks++;
        if (vals !== 16'h87F5 || dots !== 4'b0000 || commit !== 1'b1) begin
            n_fail++;
            $display("FAIL arb_b_commit: got %h/%b/%b want 87f5/0000/1", vals, dots, commit);
        end
    endtask

    task automatic test_timeout();
        tick();
        set_b(1'b1, 2'd3, 4'hD, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({busy, owner, b_ready} !== 3'b111) begin
            n_fail++;
            $display("FAIL timeout_grant_b: busy/owner/b_ready got %b want 111",
                     {busy, owner, b_ready});
        end
        tick();
        b_valid = 1'b0;
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            tick();
            n_checks++;
            if (abort !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_early_%0d: abort/busy got %b want 01", i, {abort, busy});
            end
        end
        tick();
        n_checks++;
        if ({abort, busy, b_ready, commit} !== 4'b1000) begin
            n_fail++;
            $display("FAIL timeout_abort: abort/busy/b_ready/commit got %b want 1000",
                     {abort, busy, b_ready, commit});
        end
        n_checks++;
        if (vals !== 16'h87F5 || dots !== 4'b0000) begin
            n_fail++; $display("FAIL timeout_outputs: got %h/%b want 87f5/0000", vals, dots);
        end
        set_a(1'b1, 2'd0, 4'h5, 1'b0, 1'b0);
        b_valid = 1'b1;
        tick();
        n_checks++;
        if ({abort, busy, owner, a_ready, b_ready} !== 5'b01010) begin
            n_fail++;
            $display("FAIL timeout_yield_a: abort/busy/owner/a_ready/b_ready got %b want 01010",
                     {abort, busy, owner, a_ready, b_ready});
        end
    endtask

    // A owns the grant on entry.
    task automatic test_repeat_digit();
        b_valid = 1'b0;
        set_a(1'b1, 2'd0, 4'h5, 1'b0, 1'b0);
        tick();
        set_a(1'b1, 2'd0, 4'h9, 1'b0, 1'b1);
        tick();
        a_valid = 1'b0;
        tick();
        n_checks++;
        if (vals !== 16'h87F9 || commit !== 1'b1) begin
            n_fail++; $display("FAIL repeat_digit: got %h/%b want 87f9/1", vals, commit);
        end
    endtask

    task automatic test_reset_mid_frame();
        set_a(1'b1, 2'd0, 4'h3, 1'b0, 1'b0);
        tick();
        tick();
        set_a(1'b1, 2'd1, 4'h4, 1'b0, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (vals !== 16'h0 || busy !== 1'b0 || a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: vals/busy/a_ready got %h/%b/%b want 0000/0/0",
                     vals, busy, a_ready);
        end
        a_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({commit, abort, busy, a_ready} !== 4'b0000) begin
                n_fail++;
                $display("FAIL midreset_quiet_%0d: commit/abort/busy/a_ready got %b want 0000",
                         i, {commit, abort, busy, a_ready});
            end
        end
        a_valid = 1'b1;
        tick();
        n_checks++;
        if ({busy, owner, a_ready, vals} !== {3'b101, 16'h0}) begin
            n_fail++;
            $display("FAIL midreset_regrant: busy/owner/a_ready got %b vals %h want 101/0000",
                     {busy, owner, a_ready}, vals);
        end
    endtask

    initial begin
        test_reset();
        test_frame_a();
        test_arbitration();
        test_timeout();
        test_repeat_digit();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
